// File: rtl/clk_rst_param_pkg.sv
// clk_rst_param_pkg: shared parameters, types and helpers for the clk_rst sub-IP
package clk_rst_param_pkg;

    localparam int FANOUT   = 4;
    localparam int HOLD_CYC = 4;
    localparam int GATE_CYC = 2;

    typedef logic [FANOUT-1:0] FANOUT_t;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN,
        GATE
    } clk_rst_seq_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_rst_seq_if.sv
// clk_rst_seq_if: configuration, software request and per-channel outputs of the reset sequencer
interface clk_rst_seq_if #(
    parameter int FANOUT = clk_rst_param_pkg::FANOUT,
    parameter int DLY_W  = 8
) ();

    logic [DLY_W-1:0]  dly_cfg;
    logic              sw_rst_req;
    logic [FANOUT-1:0] sw_rst_mask;
    logic [FANOUT-1:0] ch_rst_n_o;
    logic [FANOUT-1:0] ch_clk_en_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output dly_cfg, sw_rst_req, sw_rst_mask,
        input  ch_rst_n_o, ch_clk_en_o, busy_o, done_o
    );

    modport slave (
        input  dly_cfg, sw_rst_req, sw_rst_mask,
        output ch_rst_n_o, ch_clk_en_o, busy_o, done_o
    );

endinterface

// File: rtl/clk_rst_next_bit.sv
// clk_rst_next_bit: next set bit of a mask above idx (lowest set bit when first), last when none remains
module clk_rst_next_bit #(
    parameter int FANOUT = clk_rst_param_pkg::FANOUT
) (
    input  logic [FANOUT-1:0]                              mask,
    input  logic [clk_rst_param_pkg::idx_w(FANOUT)-1:0]    idx,
    input  logic                                           first,
    output logic [clk_rst_param_pkg::idx_w(FANOUT)-1:0]    nxt,
    output logic                                           last
);

    localparam int IW = clk_rst_param_pkg::idx_w(FANOUT);

    // scan downwards so the lowest qualifying bit is the one that sticks
    always_comb begin
        nxt  = '0;
        last = 1'b1;
        for (int i = FANOUT - 1; i >= 0; i--) begin
            if (mask[i] && (first || i > int'(idx))) begin
                nxt  = i[IW-1:0];
                last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: staggered per-channel reset release with software re-reset and clock gating
module clk_rst_seq #(
    parameter int FANOUT = clk_rst_param_pkg::FANOUT,
    parameter int DLY_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    clk_rst_seq_if.slave bus
);

    import clk_rst_param_pkg::*;

    localparam int IW = idx_w(FANOUT);

    clk_rst_seq_state_e state, state_d;
    FANOUT_t            tgt, tgt_d, rst_q, rst_d, en_q, en_d;
    logic [DLY_W-1:0]   cnt, cnt_d, dly_q, dly_d;
    logic [IW-1:0]      idx, idx_d, nb_idx;
    logic               done_q, done_d, nb_last;

    clk_rst_next_bit #(.FANOUT(FANOUT)) u_next_bit (
        .mask  (tgt),
        .idx   (idx),
        .first (state == HOLD),
        .nxt   (nb_idx),
        .last  (nb_last)
    );

    // next-state and next-output logic; every register holds unless a branch changes it
    always_comb begin
        state_d = state;
        tgt_d   = tgt;
        cnt_d   = cnt;
        dly_d   = dly_q;
        idx_d   = idx;
        rst_d   = rst_q;
        en_d    = en_q;
        done_d  = 1'b0;
        case (state)
            HOLD: begin
                if (cnt == DLY_W'(HOLD_CYC - 1)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = nb_idx;
                    dly_d   = bus.dly_cfg;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (cnt == dly_q) begin
                    rst_d[idx] = 1'b1;
                    cnt_d      = '0;
                    dly_d      = bus.dly_cfg;
                    idx_d      = nb_last ? idx : nb_idx;
                    state_d    = nb_last ? RUN : RELEASE;
                    done_d     = nb_last;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RUN: begin
                if (bus.sw_rst_req && |bus.sw_rst_mask) begin
                    state_d = GATE;
                    tgt_d   = bus.sw_rst_mask;
                    en_d    = en_q & ~bus.sw_rst_mask;
                    cnt_d   = '0;
                end
            end
            GATE: begin
                if (cnt == DLY_W'(GATE_CYC - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    rst_d   = rst_q & ~tgt;
                    en_d    = en_q | tgt;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
        endcase
    end

    // state and output registers; reset restarts the full power-on sequence on all channels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= HOLD;
            tgt    <= '1;
            cnt    <= '0;
            dly_q  <= '0;
            idx    <= '0;
            rst_q  <= '0;
            en_q   <= '1;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            tgt    <= tgt_d;
            cnt    <= cnt_d;
            dly_q  <= dly_d;
            idx    <= idx_d;
            rst_q  <= rst_d;
            en_q   <= en_d;
            done_q <= done_d;
        end
    end

    assign bus.ch_rst_n_o  = rst_q;
    assign bus.ch_clk_en_o = en_q;
    assign bus.busy_o      = (state != RUN);
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: table-driven, directed and randomized checks of clk_rst_seq against a schedule model
module tb_clk_rst_seq;

    localparam int FANOUT = 4;
    localparam int DLY_W  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clk_rst_seq_if #(.FANOUT(FANOUT), .DLY_W(DLY_W)) bus ();

    clk_rst_seq #(.FANOUT(FANOUT), .DLY_W(DLY_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         edge_n;
        logic [3:0] rst;
        logic [3:0] en;
        logic       busy;
        logic       done;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int         e;
    int         hold_end, gate_end, next_rel;
    int         q[$];
    logic [3:0] m_rst, m_en, m_tgt;
    logic       m_busy, m_done;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.ch_rst_n_o, bus.ch_clk_en_o, bus.busy_o, bus.done_o});
    endfunction

    task automatic start_hold(input logic [3:0] t);
        m_tgt    = t;
        hold_end = e + 4;
        next_rel = -1;
        q.delete();
        for (int i = 0; i < FANOUT; i++)
            if (t[i]) q.push_back(i);
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (!rst_n) begin
            e        = 0;
            gate_end = -1;
            m_rst    = '0;
            m_en     = '1;
            m_busy   = 1'b1;
            start_hold(4'hF);
            return;
        end
        e++;
        if (e == gate_end) begin
            m_rst    = m_rst & ~m_tgt;
            m_en     = m_en | m_tgt;
            gate_end = -1;
            start_hold(m_tgt);
        end else if (e == hold_end) begin
            hold_end = -1;
            next_rel = e + int'(bus.dly_cfg) + 1;
        end else if (e == next_rel) begin
            m_rst[q.pop_front()] = 1'b1;
            if (q.size() == 0) begin
                m_done   = 1'b1;
                m_busy   = 1'b0;
                next_rel = -1;
            end else begin
                next_rel = e + int'(bus.dly_cfg) + 1;
            end
        end else if (!m_busy && bus.sw_rst_req && bus.sw_rst_mask != 0) begin
            m_tgt    = bus.sw_rst_mask;
            m_en     = m_en & ~bus.sw_rst_mask;
            m_busy   = 1'b1;
            gate_end = e + 2;
        end
    endtask

    task automatic step(input logic r, input logic [7:0] d, input logic rq, input logic [3:0] m);
        @(negedge clk);
        rst_n           = r;
        bus.dly_cfg     = d;
        bus.sw_rst_req  = rq;
        bus.sw_rst_mask = m;
        @(posedge clk);
        model_edge();
        #1;
        check("model", outs(), int'({m_rst, m_en, m_busy, m_done}));
    endtask

    task automatic run(input int n, input logic [7:0] d);
        while (e < n) step(1'b1, d, 1'b0, 4'h0);
    endtask

    task automatic run_to_done(input int budget, input logic [7:0] d, output int done_e);
        done_e = -1;
        for (int k = 0; k < budget && done_e < 0; k++) begin
            step(1'b1, d, 1'b0, 4'h0);
            if (bus.done_o) done_e = e;
        end
    endtask

    initial begin
        vec_t tbl[9];
        int   r, t1, t3, td, kept;

        tbl[0] = '{4,  4'b0000, 4'b1111, 1'b1, 1'b0};
        tbl[1] = '{7,  4'b0000, 4'b1111, 1'b1, 1'b0};
        tbl[2] = '{8,  4'b0001, 4'b1111, 1'b1, 1'b0};
        tbl[3] = '{11, 4'b0001, 4'b1111, 1'b1, 1'b0};
        tbl[4] = '{12, 4'b0011, 4'b1111, 1'b1, 1'b0};
        tbl[5] = '{16, 4'b0111, 4'b1111, 1'b1, 1'b0};
        tbl[6] = '{19, 4'b0111, 4'b1111, 1'b1, 1'b0};
        tbl[7] = '{20, 4'b1111, 4'b1111, 1'b0, 1'b1};
        tbl[8] = '{21, 4'b1111, 4'b1111, 1'b0, 1'b0};

        e               = 0;
        bus.dly_cfg     = 8'd3;
        bus.sw_rst_req  = 1'b0;
        bus.sw_rst_mask = 4'h0;

        step(1'b0, 8'd3, 1'b0, 4'h0);
        step(1'b0, 8'd3, 1'b0, 4'h0);
        check("reset_state", outs(), int'(10'b0000_1111_1_0));

        for (int i = 0; i < 9; i++) begin
            run(tbl[i].edge_n, 8'd3);
            check($sformatf("pwr_e%0d", tbl[i].edge_n), outs(),
                  int'({tbl[i].rst, tbl[i].en, tbl[i].busy, tbl[i].done}));
        end

        step(1'b1, 8'd3, 1'b1, 4'h0);
        check("mask0_ignored", outs(), int'(10'b1111_1111_0_0));
        step(1'b1, 8'd3, 1'b1, 4'b1010);
        r = e;
        check("gate_en", outs(), int'(10'b1111_0101_1_0));
        step(1'b1, 8'd3, 1'b1, 4'b0001);
        check("gate_req_dropped", outs(), int'(10'b1111_0101_1_0));
        step(1'b1, 8'd3, 1'b0, 4'h0);
        check("gate_exit", outs(), int'(10'b0101_1111_1_0));
        t1 = -1;
        t3 = -1;
        td = -1;
        kept = 1;
        for (int k = 0; k < 40 && td < 0; k++) begin
            step(1'b1, 8'd3, 1'b0, 4'h0);
            if ((bus.ch_rst_n_o & 4'b0101) != 4'b0101) kept = 0;
            if (bus.ch_rst_n_o[1] && t1 < 0) t1 = e;
            if (bus.ch_rst_n_o[3] && t3 < 0) t3 = e;
            if (bus.done_o) td = e;
        end
        check("sw_ch1_rise", t1, r + 10);
        check("sw_ch3_rise", t3, r + 14);
        check("sw_done", td, r + 14);
        check("sw_untouched", kept, 1);

        step(1'b0, 8'd0, 1'b0, 4'h0);
        while (e < 18) begin
            step(1'b1, (e < 5) ? 8'd0 : 8'd5, 1'b0, 4'h0);
            if (e == 5)  check("dly0_e5",  int'(bus.ch_rst_n_o), 4'b0001);
            if (e == 6)  check("dly0_e6",  int'(bus.ch_rst_n_o), 4'b0011);
            if (e == 11) check("dly5_e11", int'(bus.ch_rst_n_o), 4'b0011);
            if (e == 12) check("dly5_e12", int'(bus.ch_rst_n_o), 4'b0111);
            if (e == 18) check("dly5_e18", outs(), int'(10'b1111_1111_0_1));
        end

        step(1'b0, 8'd2, 1'b0, 4'h0);
        run(7, 8'd2);
        check("mid_ch0", int'(bus.ch_rst_n_o), 4'b0001);
        step(1'b1, 8'd2, 1'b0, 4'h0);
        step(1'b0, 8'd2, 1'b0, 4'h0);
        check("mid_reset", outs(), int'(10'b0000_1111_1_0));
        run_to_done(40, 8'd2, td);
        check("mid_restart_done", td, 16);

        step(1'b0, 8'hFF, 1'b0, 4'h0);
        run(259, 8'hFF);
        check("ff_e259", int'(bus.ch_rst_n_o), 4'b0000);
        run(260, 8'hFF);
        check("ff_e260", int'(bus.ch_rst_n_o), 4'b0001);
        run_to_done(1100, 8'hFF, td);
        check("ff_done", td, 1028);

        for (int i = 0; i < 3000; i++) begin
            logic       rr, rq;
            logic [7:0] d;
            logic [3:0] m;
            rr = ($urandom_range(0, 299) != 0);
            d  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 20)) : 8'($urandom_range(0, 3));
            rq = ($urandom_range(0, 5) == 0);
            m  = 4'($urandom);
            step(rr, d, rq, m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Parametrised reset-release sequencer and clock-enable controller for the clk_rst sub-IP. It drives FANOUT per-channel active-low resets and clock enables. Out of reset it releases the channels one at a time, in ascending index order, with a programmable spacing between releases. At run time, a software request re-resets any subset of channels: it gates their clocks, re-asserts their resets, then re-releases them in sequence. It sits between the harness top-level clock/reset and the DUT/agent reset domains, replacing fixed-width, all-at-once reset fanout.

## Interface
- FANOUT, default clk_rst_param_pkg::FANOUT (4 in unit bench): number of channels.
- DLY_W, default 8: width of the inter-release delay field.
- clk  in  1: sole clock.
- rst_n  in  1: synchronous, active-low reset.
- dly_cfg  in  DLY_W: cycles between successive channel releases, minus 1.
- sw_rst_req  in  1: single-cycle software reset request.
- sw_rst_mask  in  FANOUT: channels to re-reset; sampled with sw_rst_req.
- ch_rst_n_o  out  FANOUT: per-channel active-low reset.
- ch_clk_en_o  out  FANOUT: per-channel clock enable.
- busy_o  out  1: sequence in progress.
- done_o  out  1: one-cycle pulse when a sequence completes.

## Operation
- States:
  - HOLD: target channels held in reset, clocks enabled, counter running.
  - RELEASE: walk the set bits of the target mask.
  - RUN: idle.
  - GATE: clocks of target channels off.
- Reset (rst_n=0, sampled on a clk edge):
  - state=HOLD, target=all ones, cnt=0.
  - ch_rst_n_o=0, ch_clk_en_o=all ones, busy_o=1, done_o=0.
- HOLD:
  - Lasts HOLD_CYC=4 cycles, then → RELEASE.
  - idx = lowest set bit of target; cnt=0; dly_cfg is latched.
- RELEASE:
  - When cnt == latched dly_cfg, deassert ch_rst_n_o[idx]; idx = next higher set bit of target; cnt=0; re-latch dly_cfg.
  - Otherwise cnt++.
  - After the highest set bit is released → RUN, with done_o=1 for one cycle.
- RUN: busy_o=0.
  - sw_rst_req=1 with sw_rst_mask≠0 → GATE, target=sw_rst_mask.
  - ch_clk_en_o[target] drops on the next cycle.
- GATE:
  - Lasts GATE_CYC=2 cycles.
  - On exit: ch_rst_n_o[target]=0 and ch_clk_en_o[target]=1 in the same cycle, → HOLD.
- Channels outside target are never touched by a software sequence.
- Boundary rules:
  - sw_rst_req with mask=0: ignored.
  - sw_rst_req while busy_o=1: dropped (no queue, no error).
  - dly_cfg=0: one cycle per release, i.e. a release on every RELEASE cycle.
  - dly_cfg all ones: 2^DLY_W cycles.
  - The counter is DLY_W bits and never wraps past the compare.
  - dly_cfg changes mid-sequence: take effect at the next channel, never the current one.
  - rst_n low in any state: returns to the reset values on the next edge, abandoning the sequence.
  - Single-bit target: HOLD → one RELEASE wait → RUN.

## Timing
- Edge n = nth rising edge with rst_n=1 sampled. HOLD_CYC=4.
- Channel k (k-th released) goes high after edge 4 + (k+1)·(dly_cfg+1).
- done_o is high in the same cycle the last ch_rst_n_o bit is first high; busy_o falls in that cycle.
- Software path, request at edge r:
  - ch_clk_en_o low after edge r.
  - ch_rst_n_o low and clock re-enabled after edge r+2.
  - First release after edge r+2+4+(dly_cfg+1).
- All outputs are registered; no combinational input-to-output path.

## Structure
- Additions to clk_rst_param_pkg:
  - state enum clk_rst_seq_state_e {HOLD, RELEASE, RUN, GATE}.
  - localparams HOLD_CYC=4 and GATE_CYC=2.
  - existing FANOUT_t, used for all mask-typed signals.
- Sub-module clk_rst_next_bit: combinational, parametrised by FANOUT. Given a mask and the current idx, it returns the next higher set index plus a "last" flag. It is shared by the initial idx pick (idx=-1 semantics) and the advance step.

## Test plan
- Power-on, FANOUT=4, dly_cfg=3: channels rise after edges 8, 12, 16, 20; done_o is a single pulse with busy_o falling in the edge-20 cycle.
- dly_cfg=0: releases after edges 5, 6, 7, 8; dly_cfg changed from 0 to 5 after edge 5 → ch1 still rises at 6, ch2 rises at 12.
- In RUN, sw_rst_req with mask=4'b1010 at edge r:
  - ch_clk_en_o=4'b0101 for 2 cycles, then ch_rst_n_o=4'b0101.
  - ch1 and ch3 re-release in order.
  - ch0 and ch2 stay high throughout.
- sw_rst_req with mask=0, and sw_rst_req during a sequence: no output change, no done_o.
- rst_n pulsed low mid-RELEASE after ch0 released: all ch_rst_n_o=0, busy_o=1, and the full sequence restarts from edge 1.
- dly_cfg=8'hFF: 256-cycle spacing, counter does not wrap (ch0 rises after edge 260).
